// File: rtl/ram_dual_master_arbiter.sv
// Round-robin arbiter sharing one single-port Avalon-MM RAM between two masters.
// Optional address bounds check enabled by defining RAM_ARB_BOUNDS_CHECK_EN.
module ram_dual_master_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4,
  parameter int unsigned DEPTH  = 10000,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              oob_err
);

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              active;
  logic              prio_q, prio_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;
  logic [RD_LAT-1:0] pipe_oob_q, pipe_oob_d;
  logic              oob_err_q, oob_err_d;

  logic              m0_req, m1_req, both_req, any_req;
  logic              gnt_id, gnt_write, gnt_read, oob_hit;
  logic [ADDR_W-1:0] gnt_addr;
  logic              last_vld, last_id, last_oob;
  logic [DATA_W-1:0] ret_data;

  // Internal reset releases two clocks after reset_n rises so grants start cleanly.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end
  assign active = rst_sync_q[1];

  always_comb begin
    m0_req   = m0_read | m0_write;
    m1_req   = m1_read | m1_write;
    both_req = m0_req & m1_req;
    any_req  = active & (m0_req | m1_req);
    gnt_id   = both_req ? prio_q : m1_req;
    gnt_addr = gnt_id ? m1_address : m0_address;
    gnt_write = gnt_id ? m1_write : m0_write;
    gnt_read  = any_req & ~gnt_write;
    oob_hit   = OOB_EN & any_req & (32'(gnt_addr) >= DEPTH);
  end

  always_comb begin
    m0_waitrequest = ~active | (both_req & gnt_id);
    m1_waitrequest = ~active | (both_req & ~gnt_id);
    ram_address    = gnt_addr;
    ram_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
    ram_writedata  = gnt_id ? m1_writedata : m0_writedata;
    ram_chipselect = any_req & ~oob_hit;
    ram_write      = any_req & gnt_write & ~oob_hit;
    ram_clken      = reset_n;
  end

  // Only a contended grant rotates priority, so an idle master never loses its turn.
  always_comb begin
    prio_d    = (active & both_req) ? ~gnt_id : prio_q;
    oob_err_d = oob_err_q | oob_hit;
    pipe_vld_d[0] = gnt_read;
    pipe_id_d[0]  = gnt_id;
    pipe_oob_d[0] = oob_hit;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
      pipe_oob_d[i] = pipe_oob_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
      prio_q     <= 1'b0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
      pipe_oob_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      prio_q     <= prio_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
      pipe_oob_q <= pipe_oob_d;
      oob_err_q  <= oob_err_d;
    end
  end

  // Out-of-range reads never touched the RAM, so they return zero instead of stale data.
  always_comb begin
    last_vld = pipe_vld_q[RD_LAT-1];
    last_id  = pipe_id_q[RD_LAT-1];
    last_oob = pipe_oob_q[RD_LAT-1];
    ret_data = last_oob ? '0 : ram_readdata;
    m0_readdatavalid = last_vld & ~last_id;
    m1_readdatavalid = last_vld & last_id;
    m0_readdata = m0_readdatavalid ? ret_data : '0;
    m1_readdata = m1_readdatavalid ? ret_data : '0;
    oob_err = oob_err_q;
  end

endmodule

// File: tb/tb_ram_dual_master_arbiter.sv
// Bench for ram_dual_master_arbiter: directed and random traffic against a shadow-memory model.
module tb_ram_dual_master_arbiter;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [13:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];

  logic [13:0] m0_address, m1_address, ram_address;
  logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        ram_chipselect, ram_write, ram_clken, oob_err;
  logic [31:0] ram_writedata;
  bit   [31:0] ram_readdata;

  bit [31:0] ram_mem [16384];
  bit [31:0] shadow [16384];

  int checks = 0;
  int fails = 0;
  bit prio_m;
  bit pend_v;
  bit pend_id;
  logic [31:0] pend_d;
  bit oob_m;
  int gcnt [2];
  logic [31:0] last_rd0, last_rd1;

  assign m0_address = addr[0];  assign m1_address = addr[1];
  assign m0_byteenable = be[0]; assign m1_byteenable = be[1];
  assign m0_read = rd[0];       assign m1_read = rd[1];
  assign m0_write = wr[0];      assign m1_write = wr[1];
  assign m0_writedata = wd[0];  assign m1_writedata = wd[1];

  ram_dual_master_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic set_m(input int i, input logic r, input logic w, input logic [13:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) set_m(i, 1'b0, 1'b0, 14'd0, 4'd0, 32'd0);
  endtask

  // Called at a negedge: pulse reset for one cycle, then wait out the internal release
  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    #1;
    chk("rst_m0_waitrequest", {31'd0, m0_waitrequest}, 32'd1);
    chk("rst_m1_waitrequest", {31'd0, m1_waitrequest}, 32'd1);
    chk("rst_ram_chipselect", {31'd0, ram_chipselect}, 32'd0);
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_ram_clken", {31'd0, ram_clken}, 32'd0);
    chk("rst_m0_readdatavalid", {31'd0, m0_readdatavalid}, 32'd0);
    chk("rst_m1_readdatavalid", {31'd0, m1_readdatavalid}, 32'd0);
    chk("rst_m0_readdata", m0_readdata, 32'd0);
    chk("rst_m1_readdata", m1_readdata, 32'd0);
    chk("rst_oob_err", {31'd0, oob_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prio_m = 1'b0; pend_v = 1'b0; pend_id = 1'b0; pend_d = '0; oob_m = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One bus cycle: check DUT against the model, advance the model, drop the granted request
  task automatic cycle();
    bit r0, r1, both, any, g, gw, oob, ev0, ev1;
    logic [13:0] ga;
    logic [3:0]  gbe;
    logic [31:0] gd;
    #1;
    r0 = rd[0] | wr[0];
    r1 = rd[1] | wr[1];
    both = r0 && r1;
    any = r0 || r1;
    g = both ? prio_m : r1;
    gw = wr[g]; ga = addr[g]; gbe = be[g]; gd = wd[g];
    oob = BC && any && (int'(ga) >= 10000);
    chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, both && g});
    chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, both && !g});
    chk("ram_chipselect", {31'd0, ram_chipselect}, {31'd0, any && !oob});
    chk("ram_write", {31'd0, ram_write}, {31'd0, any && gw && !oob});
    if (any && !oob) begin
      chk("ram_address", {18'd0, ram_address}, {18'd0, ga});
      chk("ram_byteenable", {28'd0, ram_byteenable}, {28'd0, gbe});
      if (gw) chk("ram_writedata", ram_writedata, gd);
    end
    ev0 = pend_v && !pend_id;
    ev1 = pend_v && pend_id;
    chk("m0_readdatavalid", {31'd0, m0_readdatavalid}, {31'd0, ev0});
    chk("m1_readdatavalid", {31'd0, m1_readdatavalid}, {31'd0, ev1});
    chk("m0_readdata", m0_readdata, ev0 ? pend_d : 32'd0);
    chk("m1_readdata", m1_readdata, ev1 ? pend_d : 32'd0);
    chk("oob_err", {31'd0, oob_err}, {31'd0, oob_m});
    if (m0_readdatavalid === 1'b1) last_rd0 = m0_readdata;
    if (m1_readdatavalid === 1'b1) last_rd1 = m1_readdata;
    pend_v = 1'b0;
    if (any) begin
      gcnt[g]++;
      if (gw) begin
        if (!oob)
          for (int b = 0; b < 4; b++)
            if (gbe[b]) shadow[int'(ga)][8*b +: 8] = gd[8*b +: 8];
      end else begin
        pend_v = 1'b1;
        pend_id = g;
        pend_d = oob ? 32'd0 : shadow[int'(ga)];
      end
      if (oob) oob_m = 1'b1;
      if (both) prio_m = !g;
    end
    @(posedge clk);
    @(negedge clk);
    if (any) begin
      rd[g] = 1'b0;
      wr[g] = 1'b0;
    end
  endtask

  task automatic fill_random();
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!(rd[i] || wr[i])) begin
        k = $urandom_range(0, 3);
        set_m(i, (k == 1) || (k == 3), k >= 2, 14'($urandom_range(0, 31)),
              4'($urandom_range(0, 15)), $urandom);
      end
    end
  endtask

  initial begin
    idle_all();
    last_rd0 = '0; last_rd1 = '0;
    @(negedge clk);
    do_reset();

    // Write then read back on master 0
    set_m(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
    cycle();
    set_m(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'd0);
    cycle();
    cycle();
    chk("m0_readback", last_rd0, 32'hDEADBEEF);

    // Simultaneous reads: m0 first, m1 one cycle later
    set_m(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'd0);
    set_m(1, 1'b1, 1'b0, 14'h0010, 4'hF, 32'd0);
    repeat (3) cycle();
    chk("m1_contended_read", last_rd1, 32'hDEADBEEF);

    // Continuous writes from both masters alternate grants
    do_reset();
    gcnt[0] = 0; gcnt[1] = 0;
    for (int j = 0; j < 8; j++) begin
      if (!wr[0]) set_m(0, 1'b0, 1'b1, 14'(32 + j), 4'hF, 32'hA000_0000 + j);
      if (!wr[1]) set_m(1, 1'b0, 1'b1, 14'(48 + j), 4'hF, 32'hB000_0000 + j);
      cycle();
    end
    chk("m0_write_count", gcnt[0], 32'd4);
    chk("m1_write_count", gcnt[1], 32'd4);
    idle_all();
    cycle();

    // Byte-enable merge on master 1
    set_m(1, 1'b0, 1'b1, 14'd5, 4'hF, 32'hFFFFFFFF);
    cycle();
    set_m(1, 1'b0, 1'b1, 14'd5, 4'h3, 32'h11223344);
    cycle();
    set_m(1, 1'b1, 1'b0, 14'd5, 4'hF, 32'd0);
    cycle();
    cycle();
    chk("m1_byteenable_merge", last_rd1, 32'hFFFF3344);

    // Reset in the cycle after an m0 read grant drops the return
    set_m(0, 1'b1, 1'b0, 14'h0010, 4'hF, 32'd0);
    cycle();
    do_reset();
    repeat (2) cycle();
    set_m(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'd0);
    set_m(1, 1'b1, 1'b0, 14'h0010, 4'hF, 32'd0);
    repeat (3) cycle();

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    set_m(0, 1'b0, 1'b1, 14'd10000, 4'hF, 32'h12345678);
    cycle();
    set_m(0, 1'b1, 1'b0, 14'd10000, 4'hF, 32'd0);
    last_rd0 = 32'hFFFFFFFF;
    cycle();
    cycle();
    chk("oob_read_data", last_rd0, 32'd0);
    repeat (3) cycle();
    chk("oob_err_sticky", {31'd0, oob_err}, 32'd1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      fill_random();
      cycle();
    end
    idle_all();
    repeat (2) cycle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
